// File: rtl/wb_stage.sv
// wb_stage -- writeback stage feeding the GPR file write port.
//
// Accepts retiring instructions from EXU over in_valid/in_ready. Non-loads
// write in_alu_result one cycle after transfer. Loads wait in WAIT_MEM for
// the memory read response, then lane-select and extend it according to
// funct3 before writing. Every retiring instruction produces one
// commit_valid pulse, whether or not it writes a register.
//
// Parameters
//   TIMEOUT_CYCLES : WAIT_MEM cycles before a load is abandoned.
//                    This parameter is used only when WB_TIMEOUT_EN is defined.
//
// Optional feature macro
//   WB_TIMEOUT_EN  : when defined, a load that waits TIMEOUT_CYCLES cycles
//                    without mem_rvalid is dropped, and err_timeout is set.
//                    err_timeout stays set until rst. When the macro is
//                    undefined, WAIT_MEM waits indefinitely and err_timeout
//                    is tied to 0.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   in_valid/in_ready        EXU handshake
//   in_rd, in_wen            destination register and write enable
//   in_is_load, in_funct3,   load select, load type, and address bits [1:0]
//   in_addr_lo
//   in_alu_result, in_pc     non-load result and instruction PC
//   mem_rvalid/mem_rready,   memory read response handshake and data
//   mem_rdata
//   RegWEn, addr_towrite,    regfile write port (one-cycle write in WRITE)
//   data_towrite
//   commit_valid, commit_pc  retire pulse and PC
//   err_timeout              sticky load-timeout flag
module wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        mem_rready,
  output logic        RegWEn,
  output logic [4:0]  addr_towrite,
  output logic [31:0] data_towrite,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_MEM,
    S_WRITE
  } state_t;

  state_t state, state_nx;

  logic [4:0]  ld_rd;
  logic        ld_wen;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_pc;

  logic xfer;
  logic alu_xfer;
  logic load_done;
  logic timeout_hit;

  function automatic logic [31:0] load_format(input logic [2:0]  f3,
                                              input logic [1:0]  alo,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] shifted;
    shifted = word >> {alo, 3'b000};
    b = shifted[7:0];
    // Half-word lane uses only addr bit 1; misaligned halves are not trapped.
    h = alo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_format = {{24{b[7]}}, b};
      3'b100:  load_format = {24'h000000, b};
      3'b001:  load_format = {{16{h[15]}}, h};
      3'b101:  load_format = {16'h0000, h};
      default: load_format = word;
    endcase
  endfunction

  assign in_ready   = (state == S_IDLE) || (state == S_WRITE);
  assign mem_rready = (state == S_WAIT_MEM);
  assign xfer       = in_valid && in_ready;
  assign alu_xfer   = xfer && !in_is_load;
  assign load_done  = (state == S_WAIT_MEM) && mem_rvalid;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt;

  // The expiry cycle is the one in which the count would reach
  // TIMEOUT_CYCLES. A response in that same cycle still completes normally.
  assign timeout_hit = (state == S_WAIT_MEM) && !mem_rvalid &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (xfer && in_is_load)
        wait_cnt <= '0;
      else if ((state == S_WAIT_MEM) && !mem_rvalid)
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit)
        err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_WRITE: begin
        if (xfer)
          state_nx = in_is_load ? S_WAIT_MEM : S_WRITE;
        else
          state_nx = S_IDLE;
      end
      S_WAIT_MEM: begin
        if (mem_rvalid)
          state_nx = S_WRITE;
        else if (timeout_hit)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The write-port outputs are registers, loaded on the edge that enters
  // WRITE. They therefore hold their last values outside WRITE, even while
  // a later load is waiting in WAIT_MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ld_rd        <= '0;
      ld_wen       <= 1'b0;
      ld_funct3    <= '0;
      ld_addr_lo   <= '0;
      ld_pc        <= '0;
      RegWEn       <= 1'b0;
      addr_towrite <= '0;
      data_towrite <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
    end else begin
      state        <= state_nx;
      RegWEn       <= 1'b0;
      commit_valid <= 1'b0;
      if (xfer) begin
        ld_rd      <= in_rd;
        ld_wen     <= in_wen;
        ld_funct3  <= in_funct3;
        ld_addr_lo <= in_addr_lo;
        ld_pc      <= in_pc;
      end
      if (alu_xfer) begin
        RegWEn       <= in_wen && (in_rd != 5'd0);
        addr_towrite <= in_rd;
        data_towrite <= in_alu_result;
        commit_valid <= 1'b1;
        commit_pc    <= in_pc;
      end else if (load_done) begin
        RegWEn       <= ld_wen && (ld_rd != 5'd0);
        addr_towrite <= ld_rd;
        data_towrite <= load_format(ld_funct3, ld_addr_lo, mem_rdata);
        commit_valid <= 1'b1;
        commit_pc    <= ld_pc;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rready;
  logic        RegWEn;
  logic [4:0]  addr_towrite;
  logic [31:0] data_towrite;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  wb_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_wen(in_wen), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_alu_result(in_alu_result), .in_pc(in_pc),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
    .RegWEn(RegWEn), .addr_towrite(addr_towrite), .data_towrite(data_towrite),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected commit per commit_valid pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (RegWEn && !commit_valid)
        chk("regwen_without_commit", {31'd0, RegWEn}, 32'd0);
      if (commit_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_commit", {31'd0, commit_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("commit_regwen", {31'd0, RegWEn}, {31'd0, e.wen});
          chk("commit_pc", commit_pc, e.pc);
          if (e.wen) begin
            chk("commit_addr", {27'd0, addr_towrite}, {27'd0, e.rd});
            chk("commit_data", data_towrite, e.data);
          end
        end
      end
    end
  end

  // Drives one instruction and returns #1 after the edge that transfers it.
  task automatic send(input logic [4:0] rd, input logic wen, input logic ld,
                      input logic [2:0] f3, input logic [1:0] alo,
                      input logic [31:0] res, input logic [31:0] pc);
    int n;
    in_valid = 1'b1; in_rd = rd; in_wen = wen; in_is_load = ld;
    in_funct3 = f3; in_addr_lo = alo; in_alu_result = res; in_pc = pc;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_wait_bound", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic wen,
                     input logic [31:0] res, input logic [31:0] pc);
    exp_t e;
    e.wen = wen && (rd != 5'd0); e.rd = rd; e.data = res; e.pc = pc;
    sb.push_back(e);
    send(rd, wen, 1'b0, 3'b000, 2'b00, res, pc);
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo,
                      input logic [31:0] pc, input logic [31:0] rdata, input logic [31:0] exp_data);
    exp_t e;
    int n;
    e.wen = (rd != 5'd0); e.rd = rd; e.data = exp_data; e.pc = pc;
    sb.push_back(e);
    send(rd, 1'b1, 1'b1, f3, alo, 32'hBAD0BAD0, pc);
    n = 0;
    while (!mem_rready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!mem_rready) chk("mem_rready_wait_bound", {31'd0, mem_rready}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = rdata;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_wen = 1'b0; in_is_load = 1'b0;
    in_funct3 = '0; in_addr_lo = '0; in_alu_result = '0; in_pc = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_regwen", {31'd0, RegWEn}, 32'd0);
    chk("reset_commit", {31'd0, commit_valid}, 32'd0);
    chk("reset_data", data_towrite, 32'd0);
    chk("reset_mem_rready", {31'd0, mem_rready}, 32'd0);
    rst = 1'b0;
    #1 chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic ALU write; write data is visible one cycle after transfer.
    alu(5'd5, 1'b1, 32'hDEADBEEF, 32'h80000000);
    chk("alu_latency_regwen", {31'd0, RegWEn}, 32'd1);
    drain();

    // Load formatting
    load(5'd7,  3'b000, 2'd3, 32'h80000010, 32'h80FF1234, 32'hFFFFFF80);
    load(5'd8,  3'b100, 2'd3, 32'h80000014, 32'h80FF1234, 32'h00000080);
    load(5'd9,  3'b101, 2'd2, 32'h80000018, 32'h80FF1234, 32'h000080FF);
    load(5'd10, 3'b001, 2'd2, 32'h8000001C, 32'h80FF1234, 32'hFFFF80FF);
    load(5'd11, 3'b001, 2'd1, 32'h80000020, 32'h80FF1234, 32'h00001234);
    load(5'd12, 3'b011, 2'd1, 32'h80000024, 32'h80FF1234, 32'h80FF1234);
    load(5'd13, 3'b010, 2'd0, 32'h80000028, 32'h0000007F, 32'h0000007F);
    drain();

    // Three back-to-back ALU ops
    alu(5'd1, 1'b1, 32'h11111111, 32'h80000100);
    chk("b2b_regwen_1", {31'd0, RegWEn}, 32'd1);
    chk("b2b_ready_1", {31'd0, in_ready}, 32'd1);
    alu(5'd2, 1'b1, 32'h22222222, 32'h80000104);
    chk("b2b_regwen_2", {31'd0, RegWEn}, 32'd1);
    chk("b2b_ready_2", {31'd0, in_ready}, 32'd1);
    alu(5'd3, 1'b1, 32'h33333333, 32'h80000108);
    chk("b2b_regwen_3", {31'd0, RegWEn}, 32'd1);
    drain();

    // rd=0 and wen=0 still commit, but they do not write.
    alu(5'd0, 1'b1, 32'h00001234, 32'h80000200);
    alu(5'd6, 1'b0, 32'h0000ABCD, 32'h80000204);
    drain();
    chk("hold_addr_after_write", {27'd0, addr_towrite}, 32'd6);

    // Reset while a load is pending in WAIT_MEM
    send(5'd14, 1'b1, 1'b1, 3'b010, 2'd0, 32'd0, 32'h80000300);
    chk("pending_mem_rready", {31'd0, mem_rready}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    chk("rst_mid_addr", {27'd0, addr_towrite}, 32'd0);
    chk("rst_mid_data", data_towrite, 32'd0);
    chk("rst_mid_pc", commit_pc, 32'd0);
    chk("rst_mid_mem_rready", {31'd0, mem_rready}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    chk("rst_mid_no_regwen", {31'd0, RegWEn}, 32'd0);
    chk("rst_mid_data_held", data_towrite, 32'd0);

`ifdef WB_TIMEOUT_EN
    // A load with no response is abandoned after 8 WAIT_MEM cycles.
    send(5'd15, 1'b1, 1'b1, 3'b010, 2'd0, 32'd0, 32'h80000400);
    repeat (7) @(posedge clk);
    #1;
    chk("to_err_before", {31'd0, err_timeout}, 32'd0);
    chk("to_waiting", {31'd0, mem_rready}, 32'd1);
    @(posedge clk); #1;
    chk("to_err_set", {31'd0, err_timeout}, 32'd1);
    chk("to_in_ready", {31'd0, in_ready}, 32'd1);
    chk("to_mem_rready_low", {31'd0, mem_rready}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    // A response in the expiry cycle still completes normally.
    begin
      exp_t e;
      e.wen = 1'b1; e.rd = 5'd16; e.data = 32'hA5A5A5A5; e.pc = 32'h80000404;
      sb.push_back(e);
    end
    send(5'd16, 1'b1, 1'b1, 3'b010, 2'd0, 32'd0, 32'h80000404);
    repeat (7) @(posedge clk);
    #1;
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    drain();
    chk("to_err_sticky", {31'd0, err_timeout}, 32'd1);
`else
    // Without the timeout feature, a load waits as long as needed.
    begin
      exp_t e;
      e.wen = 1'b1; e.rd = 5'd17; e.data = 32'h0000FFFF; e.pc = 32'h80000500;
      sb.push_back(e);
    end
    send(5'd17, 1'b1, 1'b1, 3'b101, 2'd2, 32'd0, 32'h80000500);
    repeat (40) @(posedge clk);
    #1;
    chk("no_to_still_waiting", {31'd0, mem_rready}, 32'd1);
    chk("no_to_err", {31'd0, err_timeout}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF0000;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    drain();
`endif

    alu(5'd31, 1'b1, 32'h0BADCAFE, 32'h80000600);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_bound: simulation did not finish");
    $fatal(1);
  end

endmodule
